// File: rtl/skew_feed_ctrl.sv
// skew_feed_ctrl: streams a tile of k_len buffer vectors into a systolic skew triangle,
// generating per-lane valids and a completion pulse once the array pipeline has drained.
module skew_feed_ctrl #(
    parameter int N         = 8,
    parameter int ADDR_W    = 8,
    parameter int LEN_W     = 16,
    parameter int ARRAY_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_W-1:0]    k_len,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [32*N-1:0]     rd_data,
    output logic [32*N-1:0]     feed_data,
    output logic [N-1:0]        lane_valid,
    output logic                busy,
    output logic                done
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(N + ARRAY_LAT - 1);

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                feed_valid_q;
    logic [N-1:0]        lane_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // cnt_q holds the latched k_len counting down in FETCH, then reloads as the drain timer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = (k_len == '0) ? DONE : FETCH;
                if (k_len != '0) begin
                    cnt_d  = k_len;
                    addr_d = base_addr;
                end
            end
            FETCH: if (cnt_q == LEN_W'(1)) begin
                state_d = DRAIN;
                cnt_d   = DRAIN_LAST;
            end else begin
                cnt_d  = cnt_q - 1'b1;
                addr_d = addr_q + 1'b1;
            end
            DRAIN: if (cnt_q == '0) state_d = DONE;
                   else             cnt_d   = cnt_q - 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_en      = (state_q == FETCH);
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        rd_addr    = addr_q;
        feed_data  = feed_valid_q ? rd_data : '0;
        lane_valid = lane_q;
    end

    // lane chain is fed from rd_en so bit 0 lines up with feed_valid and keeps shifting in all states
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            addr_q       <= '0;
            feed_valid_q <= 1'b0;
            lane_q       <= '0;
        end else begin
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            feed_valid_q <= rd_en;
            lane_q       <= {lane_q[N-2:0], rd_en};
        end
    end
endmodule

// File: tb/tb_skew_feed_ctrl.sv
// tb_skew_feed_ctrl: directed cycle-by-cycle checks of skew_feed_ctrl with N=4, ARRAY_LAT=2.
module tb_skew_feed_ctrl;
    localparam int N  = 4;
    localparam int AL = 2;
    localparam logic [127:0] PAT = {4{32'hA5A5_A5A5}};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  k_len = '0;
    logic [7:0]   base_addr = '0;
    logic         rd_en;
    logic [7:0]   rd_addr;
    logic [127:0] rd_data = PAT;
    logic [127:0] feed_data;
    logic [3:0]   lane_valid;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    logic [7:0] last_addr = '0;

    skew_feed_ctrl #(.N(N), .ADDR_W(8), .LEN_W(16), .ARRAY_LAT(AL)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .base_addr(base_addr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .feed_data(feed_data),
        .lane_valid(lane_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Cycle c is observed at the negedge following accept edge c-1.
    task automatic run_tile(input string tag, input int k, input logic [7:0] base);
        int d;
        logic [3:0] lv;
        logic [7:0] ea;
        d = (k == 0) ? 1 : k + N + AL + 1;
        start = 1'b1; k_len = 16'(k); base_addr = base;
        for (int c = 1; c <= d + 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            ea = (k == 0) ? last_addr : (c <= k) ? 8'(int'(base) + c - 1) : 8'(int'(base) + k - 1);
            for (int i = 0; i < N; i++) lv[i] = (k > 0) && (c >= 2 + i) && (c <= k + 1 + i);
            chk($sformatf("%s_c%0d", tag, c), {113'd0, lane_valid, rd_en, done, busy, rd_addr},
                {113'd0, lv, c <= k, c == d, c <= d, ea});
            chk($sformatf("%s_feed_c%0d", tag, c), feed_data, lv[0] ? PAT : 128'd0);
        end
        if (k > 0) last_addr = 8'(int'(base) + k - 1);
    endtask

    initial begin
        #1;
        chk("reset_ctl", {124'd0, rd_en, busy, done, |lane_valid}, 128'd0);
        chk("reset_data", {rd_addr, feed_data[119:0]}, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        run_tile("basic", 3, 8'd10);
        run_tile("zero", 0, 8'd77);
        run_tile("wrap", 4, 8'd254);
        // start held high across a k_len=2 tile: second tile begins in cycle 11
        start = 1'b1; k_len = 16'd2; base_addr = 8'd5;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            chk($sformatf("held_c%0d", c), {125'd0, rd_en, done, busy},
                {125'd0, (c <= 2) || (c >= 11 && c <= 12), c == 9 || c == 19,
                 c <= 9 || (c >= 11 && c <= 19)});
            if (c == 11) start = 1'b0;
        end
        // reset during cycle 2 of a k_len=5 tile
        start = 1'b1; k_len = 16'd5; base_addr = 8'h20;
        @(negedge clk);
        start = 1'b0;
        chk("mid_c1", {127'd0, rd_en}, 128'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_ctl", {124'd0, rd_en, busy, done, |lane_valid}, 128'd0);
        chk("mid_rst_data", {rd_addr, feed_data[119:0]}, 128'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("mid_hold%0d", c), {126'd0, done, busy}, 128'd0);
        end
        rst = 1'b1;
        last_addr = '0;
        run_tile("post_rst", 2, 8'h40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/skew_feed_ctrl.md
SKEW_FEED_CTRL -- requirements
Module: skew_feed_ctrl

Interface
REQ-001 Parameter N, default 8: systolic array dimension, equal to the number of lanes in the input skew triangle.
REQ-002 Parameter ADDR_W, default 8: operand-buffer address width.
REQ-003 Parameter LEN_W, default 16: tile-length width.
REQ-004 Parameter ARRAY_LAT, default 2: extra drain cycles for the array pipeline after the last skewed lane.
REQ-005 clk  in  1  Single clock; all state updates on the rising edge.
REQ-006 rst  in  1  Asynchronous, active-low reset.
REQ-007 start  in  1  Tile start request.
REQ-008 k_len  in  LEN_W  Number of vectors in the tile; sampled only when start is accepted.
REQ-009 base_addr  in  ADDR_W  First buffer address of the tile; sampled only when start is accepted.
REQ-010 rd_en  out  1  Buffer read strobe.
REQ-011 rd_addr  out  ADDR_W  Buffer read address.
REQ-012 rd_data  in  32xN  Buffer read data, valid exactly one cycle after rd_en.
REQ-013 feed_data  out  32xN  Vector driven into the skew triangle inputs.
REQ-014 lane_valid  out  N  Bit i marks lane i of the skewed output as carrying tile data.
REQ-015 busy  out  1  Tile in progress.
REQ-016 done  out  1  One-cycle tile-completion pulse.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, FETCH, DRAIN and DONE.
REQ-018 In IDLE, start=1 with k_len!=0 SHALL latch k_len and base_addr and move the FSM to FETCH.
REQ-019 In IDLE, start=1 with k_len==0 SHALL move the FSM to DONE without asserting rd_en.
REQ-020 start SHALL be ignored in every state other than IDLE.
REQ-021 FETCH SHALL last exactly k_len cycles, with rd_en=1 on each of them.
REQ-022 rd_addr SHALL equal base_addr on the first FETCH cycle and increment by 1 per cycle, wrapping modulo 2^ADDR_W.
REQ-023 Outside FETCH, rd_en SHALL be 0 and rd_addr SHALL hold its last value.
REQ-024 A registered feed_valid SHALL equal rd_en delayed by one cycle.
REQ-025 feed_data SHALL equal rd_data when feed_valid=1, and all-zero otherwise, so that bubbles flush the triangle with zeros.
REQ-026 lane_valid[0] SHALL equal feed_valid, and lane_valid[i] SHALL equal feed_valid delayed by i cycles (i = 1..N-1), using its own shift chain.
REQ-027 DRAIN SHALL last exactly N+ARRAY_LAT cycles and then move the FSM to DONE.
REQ-028 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-029 busy SHALL be 1 in FETCH, DRAIN and DONE, and 0 in IDLE.
REQ-030 The lane_valid chain SHALL keep shifting in every state, so bits that are in flight drain naturally.
REQ-031 All counters SHALL be at least LEN_W bits wide.
REQ-032 k_len=2^LEN_W-1 SHALL produce that many reads without counter overflow.
REQ-033 Tile total latency from the start-accept edge to the done cycle SHALL be k_len+N+ARRAY_LAT+1 cycles.
REQ-034 A start presented in the cycle DONE is active SHALL be ignored; a start in the following IDLE cycle SHALL be accepted, giving back-to-back tiles a one-cycle gap.

Reset
REQ-035 Assertion of rst SHALL asynchronously force the FSM to IDLE.
REQ-036 Reset SHALL clear to zero: rd_en, rd_addr, busy, done, feed_valid, the lane_valid chain and the latched k_len/base_addr.
REQ-037 Reset asserted mid-FETCH or mid-DRAIN SHALL abandon the tile with no done pulse.
REQ-038 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
All scenarios use N=4, ARRAY_LAT=2, and take cycle 0 as the start-accept edge.
REQ-039 start, k_len=3, base_addr=10 -> rd_en in cycles 1-3 with rd_addr 10,11,12; feed_valid in cycles 2-4; lane_valid[3] in cycles 5-7; done only in cycle 10; busy in cycles 1-10.
REQ-040 start, k_len=0 -> done in cycle 1, rd_en never asserted, lane_valid stays 0.
REQ-041 ADDR_W=8, base_addr=254, k_len=4 -> rd_addr sequence 254,255,0,1.
REQ-042 start held high during FETCH and DONE of a k_len=2 tile -> exactly one done pulse for that tile; the next tile starts from the first IDLE cycle.
REQ-043 rst pulsed low in cycle 2 of a k_len=5 tile -> all outputs are 0 immediately, no done pulse, and a new start after reset runs a full tile correctly.
REQ-044 rd_data=0xA5A5A5A5 on all lanes held throughout -> feed_data is nonzero only in feed_valid cycles and zero elsewhere.
